// File: rtl/ub_affine_sched_ctrl_pkg.sv
// Shared types and constants for the unified-buffer affine schedule controller.
// Optional row-gap feature: UB_CTRL_ROW_GAP_EN (used by the interface and top).
package ub_ctrl_pkg;

    localparam int CTR_W    = 16;
    localparam int NUM_DIMS = 3;

    localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    // Index 1 is the innermost loop, then 2, then 0 outermost.
    typedef logic [NUM_DIMS-1:0][CTR_W-1:0] ctrl_vec_t;

    // An empty domain along any dimension means nothing ever fires.
    function automatic logic any_zero(input ctrl_vec_t ext);
        logic z;
        z = 1'b0;
        for (int i = 0; i < NUM_DIMS; i++) begin
            if (ext[i] == '0) begin
                z = 1'b1;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/ub_affine_sched_ctrl_if.sv
// Handshake/config bundle between the top-level schedule and one controller.
// With UB_CTRL_ROW_GAP_EN defined the bundle carries cfg_row_gap as well.
interface ub_affine_sched_ctrl_if;
    import ub_ctrl_pkg::*;

    logic             flush;
    logic             start;
    logic [CTR_W-1:0] cfg_start_delay;
    ctrl_vec_t        cfg_extent;
    logic [CTR_W-1:0] cfg_ii;
`ifdef UB_CTRL_ROW_GAP_EN
    logic [CTR_W-1:0] cfg_row_gap;
`endif
    logic             stall;
    logic             valid;
    ctrl_vec_t        ctrl_vars;
    logic             busy;
    logic             done;

    // The schedule side drives commands and configuration.
    modport master (
        output flush, start, cfg_start_delay, cfg_extent, cfg_ii,
`ifdef UB_CTRL_ROW_GAP_EN
        output cfg_row_gap,
`endif
        output stall,
        input  valid, ctrl_vars, busy, done
    );

    // The controller consumes commands and reports the iteration state.
    modport slave (
        input  flush, start, cfg_start_delay, cfg_extent, cfg_ii,
`ifdef UB_CTRL_ROW_GAP_EN
        input  cfg_row_gap,
`endif
        input  stall,
        output valid, ctrl_vars, busy, done
    );

endinterface

// File: rtl/ub_affine_sched_ctrl_counter_chain.sv
// Three nested loop counters, carry order var1 -> var2 -> var0.
// The final iteration holds its value so the indices stay visible at done.
module ub_ctrl_counter_chain
    import ub_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      inc,
    input  logic      clr,
    input  ctrl_vec_t extents,
    output ctrl_vec_t vars,
    output logic      last
);

    logic [NUM_DIMS-1:0] at_max;

    // Each dimension is at its top when it equals extent-1.
    always_comb begin
        at_max = '0;
        for (int i = 0; i < NUM_DIMS; i++) begin
            at_max[i] = (vars[i] == (extents[i] - CTR_ONE));
        end
    end

    assign last = &at_max;

    // Advance the carry chain on each firing; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vars <= '0;
        end else if (clr) begin
            vars <= '0;
        end else if (inc && !last) begin
            if (!at_max[1]) begin
                vars[1] <= vars[1] + CTR_ONE;
            end else begin
                vars[1] <= '0;
                if (!at_max[2]) begin
                    vars[2] <= vars[2] + CTR_ONE;
                end else begin
                    vars[2] <= '0;
                    vars[0] <= vars[0] + CTR_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/ub_affine_sched_ctrl.sv
// Schedule controller for one unified-buffer port: start delay, II pacing,
// stall/flush handling and the affine loop indices for the buffer address.
// Optional macro UB_CTRL_ROW_GAP_EN adds blanking cycles after each row wrap.
module ub_affine_sched_ctrl
    import ub_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    ub_affine_sched_ctrl_if.slave bus
);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;

    logic [CTR_W-1:0] delay_q;
    logic [CTR_W-1:0] ii_q;
    ctrl_vec_t        ext_q;
    logic [CTR_W-1:0] delay_cnt_q;
    logic [CTR_W-1:0] ii_cnt_q;

    ctrl_vec_t        vars;
    logic             last;
    logic             fire;
    logic             accept_start;
    logic             chain_clr;
    logic             delay_end;
    logic [CTR_W-1:0] ii_last;
    logic             gap_active;

`ifdef UB_CTRL_ROW_GAP_EN
    logic [CTR_W-1:0] gap_q;
    logic [CTR_W-1:0] gap_cnt_q;
    logic             row_wrap;

    assign gap_active = (gap_cnt_q != '0);
    assign row_wrap   = (vars[1] == (ext_q[1] - CTR_ONE));
`else
    assign gap_active = 1'b0;
`endif

    // An II of zero behaves exactly like an II of one.
    assign ii_last   = (ii_q == '0) ? '0 : (ii_q - CTR_ONE);
    assign delay_end = (delay_cnt_q == (delay_q - CTR_ONE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, firing decision and start acceptance; flush overrides all.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        fire         = (state_q == RUN) && (ii_cnt_q == '0) && !bus.stall
                       && !bus.flush && !gap_active;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept_start = 1'b1;
                    if (bus.cfg_start_delay != '0) begin
                        state_d = DELAY;
                    end else if (any_zero(bus.cfg_extent)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DELAY: begin
                if (delay_end) begin
                    state_d = any_zero(ext_q) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fire && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d      = IDLE;
            accept_start = 1'b0;
        end
    end

    // Configuration latch plus the delay, II and (optional) gap counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q     <= '0;
            ii_q        <= '0;
            ext_q       <= '0;
            delay_cnt_q <= '0;
            ii_cnt_q    <= '0;
`ifdef UB_CTRL_ROW_GAP_EN
            gap_q       <= '0;
            gap_cnt_q   <= '0;
`endif
        end else if (bus.flush) begin
            delay_cnt_q <= '0;
            ii_cnt_q    <= '0;
`ifdef UB_CTRL_ROW_GAP_EN
            gap_cnt_q   <= '0;
`endif
        end else if (accept_start) begin
            delay_q     <= bus.cfg_start_delay;
            ii_q        <= bus.cfg_ii;
            ext_q       <= bus.cfg_extent;
            delay_cnt_q <= '0;
            ii_cnt_q    <= '0;
`ifdef UB_CTRL_ROW_GAP_EN
            gap_q       <= bus.cfg_row_gap;
            gap_cnt_q   <= '0;
`endif
        end else begin
            if (state_q == DELAY) begin
                delay_cnt_q <= delay_cnt_q + CTR_ONE;
            end
            if ((state_q == RUN) && !bus.stall) begin
                if (gap_active) begin
`ifdef UB_CTRL_ROW_GAP_EN
                    gap_cnt_q <= gap_cnt_q - CTR_ONE;
`endif
                end else begin
                    ii_cnt_q <= (ii_cnt_q == ii_last) ? '0 : (ii_cnt_q + CTR_ONE);
`ifdef UB_CTRL_ROW_GAP_EN
                    if (fire && row_wrap && !last) begin
                        gap_cnt_q <= gap_q;
                    end
`endif
                end
            end
        end
    end

    assign chain_clr = bus.flush || accept_start;

    ub_ctrl_counter_chain u_chain (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (fire),
        .clr     (chain_clr),
        .extents (ext_q),
        .vars    (vars),
        .last    (last)
    );

    assign bus.valid     = fire;
    assign bus.ctrl_vars = vars;
    assign bus.busy      = (state_q == DELAY) || (state_q == RUN);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_ub_affine_sched_ctrl.sv
// Self-checking bench for ub_affine_sched_ctrl. The reference model works from
// the schedule rules directly: firing k of the nested loop order lands on the
// (II + gap)-th unstalled cycle after firing k-1.
// Build with UB_CTRL_ROW_GAP_EN to also exercise the row-gap feature.
module tb_ub_affine_sched_ctrl;
    import ub_ctrl_pkg::*;

    localparam int MAXC = 4400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    bit stall_at [MAXC];

    always #5 clk = ~clk;

    ub_affine_sched_ctrl_if bus ();

    ub_affine_sched_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.flush           = 1'b0;
        bus.start           = 1'b0;
        bus.stall           = 1'b0;
        bus.cfg_start_delay = '0;
        bus.cfg_extent      = '0;
        bus.cfg_ii          = '0;
`ifdef UB_CTRL_ROW_GAP_EN
        bus.cfg_row_gap     = '0;
`endif
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < MAXC; i++) begin
            stall_at[i] = 1'b0;
        end
    endtask

    // Run one schedule starting at relative cycle 0, comparing every cycle.
    task automatic test_schedule(input string name, input int e0, input int e1, input int e2,
                                 input int ii, input int d, input int gap, input bit poke);
        int        fire_c[$];
        ctrl_vec_t fire_v[$];
        ctrl_vec_t ev;
        ctrl_vec_t cfg;
        int        total, ii_eff, c, cnt, need, done_c, fi;
        bit        first, prev_wrap, exp_valid, exp_busy, exp_done;

        total     = e0 * e1 * e2;
        ii_eff    = (ii == 0) ? 1 : ii;
        first     = 1'b1;
        prev_wrap = 1'b0;
        c         = 0;
        for (int i0 = 0; i0 < e0; i0++) begin
            for (int i2 = 0; i2 < e2; i2++) begin
                for (int i1 = 0; i1 < e1; i1++) begin
                    if (first) begin
                        c = d + 1;
                        while (stall_at[c] && c < MAXC - 1) c++;
                    end else begin
                        need = ii_eff + (prev_wrap ? gap : 0);
                        cnt  = 0;
                        while (cnt < need && c < MAXC - 1) begin
                            c++;
                            if (!stall_at[c]) cnt++;
                        end
                    end
                    ev[0] = CTR_W'(i0);
                    ev[1] = CTR_W'(i1);
                    ev[2] = CTR_W'(i2);
                    fire_c.push_back(c);
                    fire_v.push_back(ev);
                    prev_wrap = (i1 == e1 - 1);
                    first     = 1'b0;
                end
            end
        end
        done_c = (total == 0) ? d + 1 : c + 1;

        cfg[0] = CTR_W'(e0);
        cfg[1] = CTR_W'(e1);
        cfg[2] = CTR_W'(e2);
        fi = 0;
        for (int r = 0; r <= done_c + 2; r++) begin
            step();
            bus.start = (r == 0) || (poke && (r == 2 || r == done_c));
            if (r == 0) begin
                bus.cfg_start_delay = CTR_W'(d);
                bus.cfg_extent      = cfg;
                bus.cfg_ii          = CTR_W'(ii);
`ifdef UB_CTRL_ROW_GAP_EN
                bus.cfg_row_gap     = CTR_W'(gap);
`endif
            end else if (poke) begin
                bus.cfg_start_delay = CTR_W'($urandom_range(0, 3));
                bus.cfg_ii          = CTR_W'($urandom_range(0, 3));
                for (int k = 0; k < NUM_DIMS; k++) begin
                    bus.cfg_extent[k] = CTR_W'($urandom_range(1, 9));
                end
            end
            bus.stall = stall_at[r];
            #1;
            exp_valid = (fi < fire_c.size()) && (fire_c[fi] == r);
            exp_busy  = (r >= 1) && (r < done_c);
            exp_done  = (r == done_c);

            vectors++;
            if (bus.valid !== exp_valid) begin
                miscompares++;
                $display("[TB] FAIL %s valid r=%0d got=%0b exp=%0b", name, r, bus.valid, exp_valid);
            end
            vectors++;
            if (bus.busy !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL %s busy r=%0d got=%0b exp=%0b", name, r, bus.busy, exp_busy);
            end
            vectors++;
            if (bus.done !== exp_done) begin
                miscompares++;
                $display("[TB] FAIL %s done r=%0d got=%0b exp=%0b", name, r, bus.done, exp_done);
            end
            if (exp_valid) begin
                vectors++;
                if (bus.ctrl_vars !== fire_v[fi]) begin
                    miscompares++;
                    $display("[TB] FAIL %s vars r=%0d got=%h exp=%h", name, r, bus.ctrl_vars, fire_v[fi]);
                end
                fi++;
            end
            if (exp_done && total > 0) begin
                vectors++;
                if (bus.ctrl_vars !== fire_v[fire_v.size()-1]) begin
                    miscompares++;
                    $display("[TB] FAIL %s final_vars got=%h exp=%h", name, bus.ctrl_vars,
                             fire_v[fire_v.size()-1]);
                end
            end
        end
        drive_idle();
        $display("[TB] %s: %0d firings, done at +%0d", name, total, done_c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        step();
        step();
        vectors++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset flags got v/b/d=%0b%0b%0b exp=000", bus.valid, bus.busy, bus.done);
        end
        vectors++;
        if (bus.ctrl_vars !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset vars got=%h exp=0", bus.ctrl_vars);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset idle busy got=%0b exp=0", bus.busy);
        end
    endtask

    task automatic test_full_sweep();
        clear_stalls();
        test_schedule("full_sweep", 1, 64, 64, 1, 0, 0, 1'b0);
    endtask

    // Start pulses while busy and in the DONE cycle must be ignored.
    task automatic test_delay_ii();
        clear_stalls();
        test_schedule("delay_ii", 1, 4, 2, 3, 5, 0, 1'b1);
    endtask

    task automatic test_stall();
        clear_stalls();
        for (int i = 9; i <= 11; i++) stall_at[i] = 1'b1;
        test_schedule("stall", 1, 4, 2, 3, 5, 0, 1'b0);
    endtask

    task automatic test_zero_extent();
        clear_stalls();
        test_schedule("zero_ext_d2", 2, 0, 4, 1, 2, 0, 1'b0);
        test_schedule("zero_ext_d0", 0, 3, 3, 2, 0, 0, 1'b0);
    endtask

    // Flush on firing index 100 of the 64x64 sweep, then flush racing start.
    task automatic test_flush();
        ctrl_vec_t ev;
        ctrl_vec_t cfg;
        bit        exp_valid;
        int        k;
        clear_stalls();
        cfg[0] = CTR_W'(1);
        cfg[1] = CTR_W'(64);
        cfg[2] = CTR_W'(64);
        for (int r = 0; r <= 101; r++) begin
            step();
            bus.start = (r == 0);
            bus.flush = (r == 101);
            if (r == 0) begin
                bus.cfg_extent      = cfg;
                bus.cfg_ii          = CTR_W'(1);
                bus.cfg_start_delay = '0;
            end
            #1;
            if (r >= 1) begin
                k         = r - 1;
                exp_valid = (r != 101);
                ev[0]     = '0;
                ev[1]     = CTR_W'(k % 64);
                ev[2]     = CTR_W'(k / 64);
                vectors++;
                if (bus.valid !== exp_valid) begin
                    miscompares++;
                    $display("[TB] FAIL flush valid r=%0d got=%0b exp=%0b", r, bus.valid, exp_valid);
                end
                vectors++;
                if (bus.ctrl_vars !== ev) begin
                    miscompares++;
                    $display("[TB] FAIL flush vars r=%0d got=%h exp=%h", r, bus.ctrl_vars, ev);
                end
            end
        end
        for (int r = 0; r < 3; r++) begin
            step();
            bus.flush = 1'b0;
            #1;
            vectors++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL post_flush flags r=%0d got v/b/d=%0b%0b%0b exp=000",
                         r, bus.valid, bus.busy, bus.done);
            end
            vectors++;
            if (bus.ctrl_vars !== '0) begin
                miscompares++;
                $display("[TB] FAIL post_flush vars got=%h exp=0", bus.ctrl_vars);
            end
        end
        step();
        bus.flush      = 1'b1;
        bus.start      = 1'b1;
        bus.cfg_extent = cfg;
        step();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            #1;
            vectors++;
            if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL flush_start busy/valid got=%0b%0b exp=00", bus.busy, bus.valid);
            end
            step();
        end
        drive_idle();
        test_schedule("flush_restart", 1, 64, 64, 1, 0, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        ctrl_vec_t cfg;
        clear_stalls();
        cfg[0] = CTR_W'(1);
        cfg[1] = CTR_W'(2);
        cfg[2] = CTR_W'(2);
        step();
        bus.start           = 1'b1;
        bus.cfg_extent      = cfg;
        bus.cfg_ii          = CTR_W'(1);
        bus.cfg_start_delay = CTR_W'(10);
        step();
        bus.start = 1'b0;
        step();
        #1;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL async_rst pre busy got=%0b exp=1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_rst flags got v/b/d=%0b%0b%0b exp=000", bus.valid, bus.busy, bus.done);
        end
        vectors++;
        if (bus.ctrl_vars !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_rst vars got=%h exp=0", bus.ctrl_vars);
        end
        #2;
        rst_n = 1'b1;
        for (int r = 0; r < 12; r++) begin
            step();
            vectors++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL async_rst after r=%0d got v/b/d=%0b%0b%0b exp=000",
                         r, bus.valid, bus.busy, bus.done);
            end
        end
        drive_idle();
    endtask

`ifdef UB_CTRL_ROW_GAP_EN
    task automatic test_row_gap();
        clear_stalls();
        test_schedule("row_gap", 1, 4, 2, 1, 0, 2, 1'b0);
        for (int i = 6; i <= 9; i++) stall_at[i] = 1'b1;
        test_schedule("row_gap_stall", 2, 3, 2, 2, 1, 3, 1'b0);
    endtask
`endif

    task automatic test_random();
        int e0, e1, e2, ii, d, gap;
        for (int it = 0; it < 10; it++) begin
            e0 = $urandom_range(1, 3);
            e1 = $urandom_range(1, 4);
            e2 = $urandom_range(1, 3);
            if ($urandom_range(0, 7) == 0) e2 = 0;
            ii = $urandom_range(0, 3);
            d  = $urandom_range(0, 4);
`ifdef UB_CTRL_ROW_GAP_EN
            gap = $urandom_range(0, 2);
`else
            gap = 0;
`endif
            for (int c = 0; c < MAXC; c++) begin
                stall_at[c] = ($urandom_range(0, 4) == 0);
            end
            test_schedule($sformatf("random%0d", it), e0, e1, e2, ii, d, gap, 1'b0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        drive_idle();
        clear_stalls();
        test_reset();
        test_full_sweep();
        test_delay_ii();
        test_stall();
        test_zero_extent();
        test_flush();
        test_async_reset();
`ifdef UB_CTRL_ROW_GAP_EN
        test_row_gap();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ub_affine_sched_ctrl.md
Name: ub_affine_sched_ctrl

Overview:
- Schedule controller for one unified-buffer port (write or read side). Generates the enable (wen/ren) and the three loop-index ctrl_vars that the buffer uses for its affine address.
- Walks a 3-deep rectangular iteration domain after a programmable start delay, firing once every II cycles.
- Honours stall and flush.
- One instance per buffer port; a top-level schedule pulses start for all instances together.

Parameters:
- CTR_W, 16, width of each loop counter, delay and II field
- NUM_DIMS, 3, number of ctrl_vars; fixed at 3 for this revision

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous restart to IDLE; overrides all other inputs
- start  in  1  one-cycle pulse; latches cfg_* and begins a schedule
- cfg_start_delay  in  CTR_W  idle cycles between start and the first firing
- cfg_extent  in  3xCTR_W  extent per dimension; index 1 innermost, then 2, then 0 outermost
- cfg_ii  in  CTR_W  cycles between consecutive firings; 0 is treated as 1
- stall  in  1  back-pressure; freezes the schedule
- valid  out  1  port enable (drives *_wen or *_ren)
- ctrl_vars  out  3xCTR_W  current iteration indices, registered
- busy  out  1  high in DELAY or RUN
- done  out  1  one-cycle pulse after the last firing

Behaviour:
- Reset, asynchronous: state=IDLE, ctrl_vars=0, delay/II counters=0, valid=0, busy=0, done=0.
- States: IDLE, DELAY, RUN, DONE.
- IDLE:
  - start=1 latches cfg_*, clears ctrl_vars and ii_cnt.
  - Next state is DELAY if cfg_start_delay>0, otherwise RUN.
  - start while busy is ignored.
- DELAY: delay counter counts up and moves to RUN after exactly cfg_start_delay cycles. First valid therefore appears D+1 cycles after the start cycle. stall does not affect DELAY.
- RUN:
  - valid = (ii_cnt==0) && !stall, combinational from registered state; ctrl_vars are stable throughout the valid cycle.
  - When valid=1, ctrl_vars advance as a carry chain: var1 increments; var1 wraps to 0 at ext1-1 and increments var2; var2 wraps at ext2-1 and increments var0.
  - ii_cnt: holds while stall=1; otherwise runs 0..II-1 and wraps, giving one firing per II unstalled cycles.
- Last firing (valid with every var at extent-1): next state DONE; ctrl_vars hold their final value.
- DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- Total firings = ext0*ext1*ext2.
- Any latched extent==0: skip RUN entirely. Go DELAY (if D>0) then DONE, with no valid.
- flush=1 in any state: next cycle is IDLE with counters cleared, no done pulse. valid is 0 in the flush cycle itself.
- Simultaneous flush and start: flush wins and start is dropped.
- All counter arithmetic is unsigned CTR_W; extents up to 2^CTR_W-1 are supported, with no overflow beyond the compare.

Optional Feature:
- Macro: UB_CTRL_ROW_GAP_EN.
- Defined:
  - Adds input cfg_row_gap (CTR_W), latched on start.
  - After each firing that wraps var1 (excluding the final firing), RUN inserts cfg_row_gap extra non-firing cycles before the next ii phase. Used to model line-blanking schedules.
  - Gap cycles do not count down while stall=1.
- Undefined: port absent, no gap logic, behaviour as above.

Decomposition:
- Package ub_ctrl_pkg holds:
  - CTR_W and NUM_DIMS localparams
  - ctrl_state_e enum {IDLE, DELAY, RUN, DONE}
  - ctrl_vec_t (array [NUM_DIMS-1:0] of logic [CTR_W-1:0])
- One sub-module, ub_ctrl_counter_chain:
  - Inputs: inc, clr, extents. Outputs: vars, last.
  - Implements the 1→2→0 carry-ordered nested counters.
- The top module holds the FSM, delay counter and II counter.

Test Plan:
- Extents {1,64,64}, II=1, D=0, start at cycle 10 → 4096 consecutive valids at cycles 11..4106. ctrl_vars[1] sweeps 0..63 and ctrl_vars[2] increments on each wrap. done at cycle 4107, busy low from 4107.
- Extents {1,4,2}, II=3, D=5, start at cycle 0 → valids at cycles 6,9,…,27 (8 firings), var pairs (0,0)…(3,1), done at cycle 28.
- Same as previous with stall high for cycles 9-11 → firing due at 9 moves to 12, later firings shift by 3, done at cycle 31; no duplicated or skipped indices.
- Extents {2,0,4}, D=2 → no valid ever; done pulses 3 cycles after start.
- Flush asserted mid-RUN at firing 100 → valid=0 that cycle, IDLE next cycle, ctrl_vars=0, no done. A new start then produces the full 4096-firing sequence.
- rst_n dropped asynchronously mid-DELAY → all outputs 0 immediately. With UB_CTRL_ROW_GAP_EN and row_gap=2, extents {1,4,2}, II=1 → valids at cycles 1-4 and 7-10 after a start at cycle 0.
